// File: rtl/wb_split_master_pkg.sv
// Shared constants for the split Wishbone initiator: bus widths, FSM encoding
// and the default watchdog limit.
package wb_split_master_pkg;

   localparam int ADR_W           = 20;
   localparam int DAT_W           = 16;
   localparam int TIMEOUT_DEFAULT = 255;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_CYC1 = 3'd1;
   localparam logic [2:0] ST_GAP  = 3'd2;
   localparam logic [2:0] ST_CYC2 = 3'd3;
   localparam logic [2:0] ST_DONE = 3'd4;

endpackage

// File: rtl/wb_split_master_watchdog.sv
// Bus watchdog: counts strobe cycles without acknowledge and flags the cycle
// in which the limit is reached so the master can abort at that same edge.
module wb_watchdog #(
   parameter logic [7:0] TIMEOUT = 8'd255
) (
   input  logic clk,
   input  logic clr,
   input  logic en,
   output logic tc
);

   logic [7:0] count;

   always_ff @(posedge clk) begin
      if (clr) begin
         count <= 8'd0;
      end else if (en) begin
         count <= count + 8'd1;
      end
   end

   // Terminal count fires while the last allowed wait cycle is in progress.
   assign tc = en && (count == TIMEOUT - 8'd1);

endmodule

// File: rtl/wb_split_master.sv
// Wishbone initiator that turns CPU requests into one or two bus cycles,
// splitting odd-address word accesses into two byte cycles.
module wb_split_master
   import wb_split_master_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             cpu_req_i,
   input  logic [ADR_W-1:0] cpu_adr_i,
   input  logic [DAT_W-1:0] cpu_dat_i,
   input  logic             cpu_we_i,
   input  logic             cpu_byte_i,
   output logic             cpu_ack_o,
   output logic [DAT_W-1:0] cpu_dat_o,
   output logic             cpu_err_o,
   output logic [ADR_W-1:0] adr_o,
   output logic [DAT_W-1:0] dat_o,
   input  logic [DAT_W-1:0] dat_i,
   output logic             we_o,
   output logic             stb_o,
   output logic             cyc_o,
   output logic             byte_o,
   input  logic             ack_i
);

   logic [2:0]       state;
   logic             pend;
   logic [ADR_W-1:0] adr_q;
   logic [DAT_W-1:0] dat_q;
   logic             we_q;
   logic             byte_q;
   logic             split_q;
   logic [7:0]       lo_q;
   logic             wd_clr;
   logic             wd_en;
   logic             wd_tc;
   logic             bus_ack;

   assign bus_ack = stb_o && ack_i;
   assign wd_en   = stb_o && !ack_i;
   assign wd_clr  = !rst_n_i || !wd_en;

   wb_watchdog #(
      .TIMEOUT(TIMEOUT[7:0])
   ) u_watchdog (
      .clk(clk_i),
      .clr(wd_clr),
      .en (wd_en),
      .tc (wd_tc)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state     <= ST_IDLE;
         pend      <= 1'b0;
         adr_q     <= '0;
         dat_q     <= '0;
         we_q      <= 1'b0;
         byte_q    <= 1'b0;
         split_q   <= 1'b0;
         lo_q      <= 8'd0;
         cpu_ack_o <= 1'b0;
         cpu_dat_o <= '0;
         cpu_err_o <= 1'b0;
         adr_o     <= '0;
         dat_o     <= '0;
         we_o      <= 1'b0;
         stb_o     <= 1'b0;
         cyc_o     <= 1'b0;
         byte_o    <= 1'b0;
      end else begin
         cpu_ack_o <= 1'b0;
         case (state)
            // A latched request spends one cycle pending before the bus is driven.
            ST_IDLE: begin
               if (pend) begin
                  pend   <= 1'b0;
                  state  <= ST_CYC1;
                  stb_o  <= 1'b1;
                  cyc_o  <= 1'b1;
                  we_o   <= we_q;
                  adr_o  <= adr_q;
                  byte_o <= split_q || byte_q;
                  dat_o  <= split_q ? {8'h00, dat_q[7:0]} : dat_q;
               end else if (cpu_req_i) begin
                  pend    <= 1'b1;
                  adr_q   <= cpu_adr_i;
                  dat_q   <= cpu_dat_i;
                  we_q    <= cpu_we_i;
                  byte_q  <= cpu_byte_i;
                  split_q <= !cpu_byte_i && cpu_adr_i[0];
               end
            end
            ST_CYC1: begin
               if (bus_ack) begin
                  stb_o <= 1'b0;
                  if (split_q) begin
                     lo_q  <= dat_i[7:0];
                     state <= ST_GAP;
                  end else begin
                     cyc_o     <= 1'b0;
                     state     <= ST_DONE;
                     cpu_ack_o <= 1'b1;
                     cpu_err_o <= 1'b0;
                     cpu_dat_o <= we_q ? '0 : dat_i;
                  end
               end else if (wd_tc) begin
                  stb_o     <= 1'b0;
                  cyc_o     <= 1'b0;
                  state     <= ST_DONE;
                  cpu_ack_o <= 1'b1;
                  cpu_err_o <= 1'b1;
                  cpu_dat_o <= '0;
               end
            end
            ST_GAP: begin
               state  <= ST_CYC2;
               stb_o  <= 1'b1;
               adr_o  <= adr_q + 20'd1;
               byte_o <= 1'b1;
               dat_o  <= {8'h00, dat_q[15:8]};
            end
            // Second half of a split access: high byte lands in result[15:8].
            ST_CYC2: begin
               if (bus_ack) begin
                  stb_o     <= 1'b0;
                  cyc_o     <= 1'b0;
                  state     <= ST_DONE;
                  cpu_ack_o <= 1'b1;
                  cpu_err_o <= 1'b0;
                  cpu_dat_o <= we_q ? '0 : {dat_i[7:0], lo_q};
               end else if (wd_tc) begin
                  stb_o     <= 1'b0;
                  cyc_o     <= 1'b0;
                  state     <= ST_DONE;
                  cpu_ack_o <= 1'b1;
                  cpu_err_o <= 1'b1;
                  cpu_dat_o <= '0;
               end
            end
            ST_DONE: begin
               state     <= ST_IDLE;
               cpu_dat_o <= '0;
               cpu_err_o <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
